// File: rtl/arbitro_mux.sv
// Round-robin arbiter driving a shared 4:1 registered mux; the winner owns the
// mux for up to MAX_TURNO captured beats, or until it drops its request.
module arbitro_mux #(
   parameter int N         = 7,
   parameter int MAX_TURNO = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [3:0]   req,
   input  logic [N:0]   a,
   input  logic [N:0]   b,
   input  logic [N:0]   c,
   input  logic [N:0]   d,
   input  logic         rs,
   input  logic         set,
   output logic [3:0]   grant,
   output logic [1:0]   selector,
   output logic [N:0]   salida,
   output logic         valida
);

   localparam logic [3:0] L_MAX = 4'(MAX_TURNO);

   typedef enum logic {
      IDLE  = 1'b0,
      SERVE = 1'b1
   } state_t;

   state_t       r_state,    w_state_next;
   logic [1:0]   r_puntero,  w_puntero_next;
   logic [3:0]   r_contador, w_contador_next;
   logic [3:0]   r_grant,    w_grant_next;
   logic [1:0]   r_selector, w_selector_next;
   logic [N:0]   r_salida,   w_salida_next;
   logic         r_valida,   w_valida_next;

   logic [1:0]   w_cand [4];
   logic [3:0]   w_hit;
   logic [1:0]   w_winner;
   logic [N:0]   w_dato_sel;
   logic [3:0]   w_cont_inc;

   // Candidate k is the k-th index in round-robin order starting at puntero.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_cand
         assign w_cand[gi] = r_puntero + 2'(gi);
         assign w_hit[gi]  = req[w_cand[gi]];
      end
   endgenerate

   always_comb begin
      w_winner = w_cand[0];
      for (int k = 3; k >= 0; k--) begin
         if (w_hit[k]) begin
            w_winner = w_cand[k];
         end
      end
   end

   always_comb begin
      w_dato_sel = a;
      case (r_selector)
         2'd0:    w_dato_sel = a;
         2'd1:    w_dato_sel = b;
         2'd2:    w_dato_sel = c;
         default: w_dato_sel = d;
      endcase
   end

   assign w_cont_inc = r_contador + 4'd1;

   always_comb begin
      w_state_next    = r_state;
      w_puntero_next  = r_puntero;
      w_contador_next = r_contador;
      w_grant_next    = r_grant;
      w_selector_next = r_selector;
      w_salida_next   = r_salida;
      w_valida_next   = 1'b0;

      // rs/set overrides touch only the output word; arbitration stays frozen.
      if (rs) begin
         w_salida_next = '0;
      end else if (set) begin
         w_salida_next = '1;
      end else begin
         case (r_state)
            IDLE: begin
               if (|req) begin
                  w_state_next    = SERVE;
                  w_grant_next    = 4'b0001 << w_winner;
                  w_selector_next = w_winner;
                  w_contador_next = 4'd0;
               end
            end
            SERVE: begin
               if (req[r_selector]) begin
                  w_salida_next   = w_dato_sel;
                  w_valida_next   = 1'b1;
                  w_contador_next = w_cont_inc;
               end
               if (!req[r_selector] || (w_cont_inc == L_MAX)) begin
                  w_state_next   = IDLE;
                  w_grant_next   = 4'b0000;
                  w_puntero_next = r_selector + 2'd1;
               end
            end
            default: begin
               w_state_next = IDLE;
               w_grant_next = 4'b0000;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_puntero  <= 2'd0;
         r_contador <= 4'd0;
         r_grant    <= 4'b0000;
         r_selector <= 2'd0;
         r_salida   <= '0;
         r_valida   <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_puntero  <= w_puntero_next;
         r_contador <= w_contador_next;
         r_grant    <= w_grant_next;
         r_selector <= w_selector_next;
         r_salida   <= w_salida_next;
         r_valida   <= w_valida_next;
      end
   end

   assign grant    = r_grant;
   assign selector = r_selector;
   assign salida   = r_salida;
   assign valida   = r_valida;

endmodule

// File: tb/tb_arbitro_mux.sv
// Bench for arbitro_mux: directed vector table, hand-written reset/rotation
// sequences, and a randomized phase checking one-hot grant and beat data.
module tb_arbitro_mux;

   localparam int N  = 7;
   localparam int MT = 4;

   typedef logic [N:0] data_t;

   logic         clk = 1'b0;
   logic         reset;
   logic [3:0]   req;
   data_t        a, b, c, d;
   logic         rs, set;
   logic [3:0]   grant;
   logic [1:0]   selector;
   data_t        salida;
   logic         valida;

   always #5 clk = ~clk;

   arbitro_mux #(.N(N), .MAX_TURNO(MT)) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .a        (a),
      .b        (b),
      .c        (c),
      .d        (d),
      .rs       (rs),
      .set      (set),
      .grant    (grant),
      .selector (selector),
      .salida   (salida),
      .valida   (valida)
   );

   typedef struct {
      logic [3:0] req;
      logic       rs;
      logic       set;
      logic [3:0] g;
      logic [1:0] s;
      data_t      o;
      logic       v;
   } vec_t;

   typedef struct {
      logic       rs;
      logic       set;
      data_t      da, db, dc, dd;
   } rin_t;

   vec_t  sb[$];
   rin_t  rq[$];
   vec_t  tbl[$];
   data_t dat[4];
   int    n_checks = 0;
   int    n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic vec_t mk(input logic [3:0] r, input logic r_s, input logic s_t,
                               input logic [3:0] g, input logic [1:0] s, input data_t o,
                               input logic v);
      vec_t t;
      t.req = r; t.rs = r_s; t.set = s_t; t.g = g; t.s = s; t.o = o; t.v = v;
      return t;
   endfunction

   // Drive one cycle of stimulus, queue its expectation, check after the edge.
   task automatic apply(input vec_t v, input string tag);
      vec_t e;
      req = v.req; rs = v.rs; set = v.set;
      sb.push_back(v);
      @(posedge clk); #1;
      e = sb.pop_front();
      $display("%s req=%b rs=%b set=%b -> grant=%b sel=%0d salida=%h valida=%b",
               tag, e.req, e.rs, e.set, grant, selector, salida, valida);
      check({tag, " grant"},    32'(grant),    32'(e.g));
      check({tag, " selector"}, 32'(selector), 32'(e.s));
      check({tag, " salida"},   32'(salida),   32'(e.o));
      check({tag, " valida"},   32'(valida),   32'(e.v));
   endtask

   task automatic check_zero(input string tag);
      $display("%s grant=%b sel=%0d salida=%h valida=%b", tag, grant, selector, salida, valida);
      check({tag, " grant"},    32'(grant),    32'd0);
      check({tag, " selector"}, 32'(selector), 32'd0);
      check({tag, " salida"},   32'(salida),   32'd0);
      check({tag, " valida"},   32'(valida),   32'd0);
   endtask

   initial begin
      rin_t       ri;
      rin_t       ro;
      data_t      last_o;
      data_t      exp_d;
      logic [3:0] oh;
      data_t      ones;

      ones   = '1;
      dat[0] = 8'h5A; dat[1] = 8'hB1; dat[2] = 8'hC2; dat[3] = 8'hD3;
      a = dat[0]; b = dat[1]; c = dat[2]; d = dat[3];
      reset = 1'b1; req = 4'b0000; rs = 1'b0; set = 1'b0;

      // Directed sequence: single requester, early drops, overrides.
      tbl.push_back(mk(4'b0001, 0, 0, 4'b0001, 2'd0, 8'h00, 0)); // grant req 0
      tbl.push_back(mk(4'b0001, 0, 0, 4'b0001, 2'd0, 8'h5A, 1));
      tbl.push_back(mk(4'b0001, 0, 0, 4'b0001, 2'd0, 8'h5A, 1));
      tbl.push_back(mk(4'b0001, 0, 0, 4'b0001, 2'd0, 8'h5A, 1));
      tbl.push_back(mk(4'b0001, 0, 0, 4'b0000, 2'd0, 8'h5A, 1)); // 4th beat releases
      tbl.push_back(mk(4'b0001, 0, 0, 4'b0001, 2'd0, 8'h5A, 0)); // regrant after bubble
      tbl.push_back(mk(4'b0100, 0, 0, 4'b0000, 2'd0, 8'h5A, 0)); // req0 dropped
      tbl.push_back(mk(4'b0100, 0, 0, 4'b0100, 2'd2, 8'h5A, 0));
      tbl.push_back(mk(4'b0100, 0, 0, 4'b0100, 2'd2, 8'hC2, 1));
      tbl.push_back(mk(4'b0000, 0, 0, 4'b0000, 2'd2, 8'hC2, 0)); // early drop, puntero=3
      tbl.push_back(mk(4'b1001, 0, 0, 4'b1000, 2'd3, 8'hC2, 0)); // 3 wins over 0
      tbl.push_back(mk(4'b1001, 0, 0, 4'b1000, 2'd3, 8'hD3, 1));
      tbl.push_back(mk(4'b1001, 0, 1, 4'b1000, 2'd3, 8'hFF, 0)); // set override
      tbl.push_back(mk(4'b1001, 0, 1, 4'b1000, 2'd3, 8'hFF, 0));
      tbl.push_back(mk(4'b1001, 1, 1, 4'b1000, 2'd3, 8'h00, 0)); // rs beats set
      tbl.push_back(mk(4'b1001, 0, 0, 4'b1000, 2'd3, 8'hD3, 1)); // resume, beat 2
      tbl.push_back(mk(4'b1001, 0, 0, 4'b1000, 2'd3, 8'hD3, 1));
      tbl.push_back(mk(4'b1001, 0, 0, 4'b0000, 2'd3, 8'hD3, 1)); // beat 4 releases
      tbl.push_back(mk(4'b1001, 0, 0, 4'b0001, 2'd0, 8'hD3, 0)); // wrap 3 -> 0
      tbl.push_back(mk(4'b0001, 0, 0, 4'b0001, 2'd0, 8'h5A, 1));
      tbl.push_back(mk(4'b0000, 0, 0, 4'b0000, 2'd0, 8'h5A, 0));
      tbl.push_back(mk(4'b0000, 0, 0, 4'b0000, 2'd0, 8'h5A, 0)); // idle holds
      tbl.push_back(mk(4'b1000, 0, 0, 4'b1000, 2'd3, 8'h5A, 0));
      tbl.push_back(mk(4'b1000, 0, 0, 4'b1000, 2'd3, 8'hD3, 1));

      repeat (2) @(posedge clk);
      #1;
      check_zero("reset_state");
      reset = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i], $sformatf("vec%0d", i));
      end

      // Asynchronous reset mid-turn clears outputs before the next edge.
      #2 reset = 1'b1;
      #1 check_zero("async_reset");
      @(negedge clk);
      reset = 1'b0;
      apply(mk(4'b1001, 0, 0, 4'b0001, 2'd0, 8'h00, 0), "post_reset");
      apply(mk(4'b1001, 0, 0, 4'b0001, 2'd0, 8'h5A, 1), "post_reset_beat");

      // Everybody requesting: rotation 0,1,2,3,0 with MT beats and one bubble.
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      last_o = '0;
      for (int t = 0; t < 5; t++) begin
         oh = 4'b0001 << (t % 4);
         apply(mk(4'hF, 0, 0, oh, 2'(t % 4), last_o, 0), $sformatf("rr%0d_grant", t));
         for (int bt = 1; bt <= MT; bt++) begin
            apply(mk(4'hF, 0, 0, (bt == MT) ? 4'b0000 : oh, 2'(t % 4), dat[t % 4], 1),
                  $sformatf("rr%0d_beat%0d", t, bt));
         end
         last_o = dat[t % 4];
      end

      // Random stimulus: structural properties only.
      for (int i = 0; i < 300; i++) begin
         ri.rs  = ($urandom_range(0, 15) == 0);
         ri.set = ($urandom_range(0, 15) == 0);
         ri.da = data_t'($urandom); ri.db = data_t'($urandom);
         ri.dc = data_t'($urandom); ri.dd = data_t'($urandom);
         req = 4'($urandom); rs = ri.rs; set = ri.set;
         a = ri.da; b = ri.db; c = ri.dc; d = ri.dd;
         rq.push_back(ri);
         @(posedge clk); #1;
         ro = rq.pop_front();
         $display("rnd%0d rs=%b set=%b -> grant=%b sel=%0d salida=%h valida=%b",
                  i, ro.rs, ro.set, grant, selector, salida, valida);
         check("rnd onehot0", 32'($countones(grant) <= 1), 32'd1);
         if (grant != 4'b0000) check("rnd grant_sel", 32'(grant), 32'(4'b0001 << selector));
         if (ro.rs) begin
            check("rnd rs_clear", 32'({salida, valida}), 32'd0);
         end else if (ro.set) begin
            check("rnd set_ones", 32'({salida, valida}), 32'({ones, 1'b0}));
         end else if (valida) begin
            case (selector)
               2'd0:    exp_d = ro.da;
               2'd1:    exp_d = ro.db;
               2'd2:    exp_d = ro.dc;
               default: exp_d = ro.dd;
            endcase
            check("rnd beat_data", 32'(salida), 32'(exp_d));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
